// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with same-cycle
// write->read bypass and a clear engine that zeroes one register per cycle.
module regfile_mp #(
  parameter int  XLEN     = 32,
  parameter int  DEPTH    = 32,
  parameter int  NUM_RD   = 2,
  parameter int  NUM_WR   = 1,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_rdata,
  input  logic [NUM_WR-1:0]      write_enable,
  input  logic [NUM_WR*AW-1:0]   rd_addr,
  input  logic [NUM_WR*XLEN-1:0] rd_wdata,
  input  logic                   clear_req,
  output logic                   clear_busy
);

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam logic [AW-1:0] ClearFirst = (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] ClearLast  = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   clear_idx_q, clear_idx_d;
  logic [XLEN-1:0] regs_q [DEPTH];
  logic [XLEN-1:0] regs_d [DEPTH];

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d     = CLEAR;
          clear_idx_d = ClearFirst;
        end
      end
      CLEAR: begin
        if (clear_idx_q == ClearLast) begin
          state_d     = IDLE;
          clear_idx_d = '0;
        end else begin
          clear_idx_d = clear_idx_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        clear_idx_d = '0;
      end
    endcase
  end

  // Clear first, then writes in port order: a same-cycle write beats the
  // clear, and port 1 beats port 0 on an address conflict.
  always_comb begin
    regs_d = regs_q;
    if (state_q == CLEAR) begin
      regs_d[clear_idx_q] = '0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (write_enable[j] && !((ZERO_REG != 0) && (rd_addr[j*AW +: AW] == '0))) begin
        regs_d[rd_addr[j*AW +: AW]] = rd_wdata[j*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clear_idx_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] rdata;

    assign raddr = rs_addr[i*AW +: AW];

    // Later write ports override earlier ones so bypass follows the write winner.
    always_comb begin
      rdata = regs_q[raddr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (write_enable[j] && (rd_addr[j*AW +: AW] == raddr)) begin
            rdata = rd_wdata[j*XLEN +: XLEN];
          end
        end
      end
      if ((ZERO_REG != 0) && (raddr == '0)) begin
        rdata = '0;
      end
    end

    assign rs_rdata[i*XLEN +: XLEN] = rdata;
  end

  assign clear_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp (two read ports,
// two write ports, x0 hardwired, bypass on) against an array/queue reference model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2*AW-1:0]   rsAddr;
  logic [2*XLEN-1:0] rsRdata;
  logic [1:0]        writeEnable;
  logic [2*AW-1:0]   rdAddr;
  logic [2*XLEN-1:0] rdWdata;
  logic              clearReq;
  logic              clearBusy;

  logic        we0, we1, creq;
  logic [4:0]  wa0, wa1, ra0, ra1;
  logic [31:0] wd0, wd1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];
  int          clrQ[$];

  assign rsAddr      = {ra1, ra0};
  assign writeEnable = {we1, we0};
  assign rdAddr      = {wa1, wa0};
  assign rdWdata     = {wd1, wd0};
  assign clearReq    = creq;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rsAddr), .rs_rdata(rsRdata),
    .write_enable(writeEnable), .rd_addr(rdAddr), .rd_wdata(rdWdata),
    .clear_req(clearReq), .clear_busy(clearBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
    if (we1 && wa1 == addr) return wd1;
    if (we0 && wa0 == addr) return wd0;
    return model[addr];
  endfunction

  task automatic checkReads(input string tag);
    checkOutput({tag, "_rd0"}, rsRdata[31:0], expRead(ra0));
    checkOutput({tag, "_rd1"}, rsRdata[63:32], expRead(ra1));
    checkOutput({tag, "_busy"}, {31'b0, clearBusy}, (clrQ.size() != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic applyStimulus(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic [4:0] r0, input logic [4:0] r1, input logic c);
    we0 = w0; wa0 = a0; wd0 = d0;
    we1 = w1; wa1 = a1; wd1 = d1;
    ra0 = r0; ra1 = r1; creq = c;
    #1;
  endtask

  task automatic modelReset();
    for (int k = 0; k < DEPTH; k++) model[k] = 32'h0;
    clrQ.delete();
  endtask

  // Advance the model by one clock edge using the current inputs, then the DUT.
  task automatic tick();
    int cl;
    cl = -1;
    if (clrQ.size() != 0) begin
      cl = clrQ.pop_front();
    end else if (creq) begin
      for (int k = 1; k < DEPTH; k++) clrQ.push_back(k);
    end
    if (cl >= 0) model[cl] = 32'h0;
    if (we0 && wa0 != 5'd0) model[wa0] = wd0;
    if (we1 && wa1 != 5'd0) model[wa1] = wd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int idx;
    rst_n = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #15;
    checkReads("reset_a");
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd5, 5'd31, 0);
    checkReads("reset_b");
    #2;
    rst_n = 1'b1;

    applyStimulus(1, 5'd0, 32'hABCDEF00, 0, 0, 0, 5'd0, 5'd0, 0);
    checkReads("x0_byp");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0);
    checkOutput("x0_p0", rsRdata[31:0], 32'h0);
    checkOutput("x0_p1", rsRdata[63:32], 32'h0);

    applyStimulus(1, 5'd5, 32'h11111111, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 5'd6, 32'h22222222, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd5, 5'd6, 0);
    checkReads("x5x6");
    checkOutput("x5", rsRdata[31:0], 32'h11111111);
    checkOutput("x6", rsRdata[63:32], 32'h22222222);

    applyStimulus(1, 5'd7, 32'hA5A5A5A5, 0, 0, 0, 5'd7, 5'd8, 0);
    checkOutput("x7_byp", rsRdata[31:0], 32'hA5A5A5A5);
    checkOutput("x8_byp", rsRdata[63:32], 32'h0);
    tick();

    applyStimulus(1, 5'd9, 32'h1, 1, 5'd9, 32'h2, 5'd9, 5'd9, 0);
    checkOutput("x9_byp", rsRdata[31:0], 32'h2);
    checkReads("x9_byp_m");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd9, 5'd7, 0);
    checkOutput("x9", rsRdata[31:0], 32'h2);
    checkReads("x9_m");

    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 39) == 0));
      checkReads("rand");
      tick();
    end

    n = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    while (clrQ.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    checkReads("drain");

    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(1, 5'(i), 32'(i), 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd4, 5'd31, 1);
    checkReads("clr_req");
    tick();
    n = 0;
    while (clearBusy === 1'b1 && n < 100) begin
      idx = (clrQ.size() != 0) ? clrQ[0] : -1;
      if (idx == 25)
        applyStimulus(1, 5'd20, 32'hDEAD, 0, 0, 0, 5'd20, 5'd25, 0);
      else if (idx == 3)
        applyStimulus(0, 0, 0, 1, 5'd3, 32'hBEEF, 5'd3, 5'd4, 1);
      else
        applyStimulus(0, 0, 0, 0, 0, 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0);
      checkReads("clr_run");
      tick();
      n++;
    end
    checkOutput("busy_cycles", 32'(n), 32'd31);
    for (int i = 0; i < DEPTH; i += 2) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 1), 0);
      checkReads("clr_done");
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd20, 0);
    checkOutput("x3_kept", rsRdata[31:0], 32'hBEEF);
    checkOutput("x20_kept", rsRdata[63:32], 32'hDEAD);

    applyStimulus(1, 5'd12, 32'h12121212, 0, 0, 0, 0, 0, 1);
    tick();
    n = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    while ((clrQ.size() == 0 || clrQ[0] != 10) && n < 100) begin
      tick();
      n++;
    end
    checkOutput("reach_idx10", {31'b0, (n < 100)}, 32'd1);
    #2;
    rst_n = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd12, 5'd20, 0);
    checkOutput("abort_busy", {31'b0, clearBusy}, 32'd0);
    checkReads("abort");
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(1, 5'd1, 32'h77, 1, 5'd2, 32'h88, 5'd1, 5'd2, 0);
    checkReads("restart");
    tick();
    n = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 0);
    while (clearBusy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("restart_cycles", 32'(n), 32'd31);
    checkReads("restart_end");
    checkOutput("x1_restart", rsRdata[31:0], 32'h77);
    checkOutput("x2_restart", rsRdata[63:32], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
